// File: rtl/sekwencer_obrotow_pkg.sv
// Shared widths, limits and FSM state type for the speed sequencer.
package sekwencer_pkg;

    localparam int RPM_W         = 7;
    localparam int TAKT_W        = 9;
    localparam int TAKT_MAX      = 511;
    localparam int SKOK_ROZRUCHU = 8;
    localparam int DZIELNA_W     = 16;

    typedef enum logic [1:0] {
        STOP      = 2'd0,
        RAMPA     = 2'd1,
        PRACA     = 2'd2,
        HAMOWANIE = 2'd3
    } stan_t;

    function automatic logic [RPM_W-1:0] krok_ku(input logic [RPM_W-1:0] rpm,
                                                  input logic [RPM_W-1:0] cel);
        return (rpm < cel) ? rpm + RPM_W'(1) : rpm - RPM_W'(1);
    endfunction

endpackage

// File: rtl/sekwencer_obrotow_if.sv
// Control inputs and LED-driver speed outputs of the speed sequencer.
interface sekwencer_obrotow_if;
    import sekwencer_pkg::*;

    logic              start;
    logic [RPM_W-1:0]  zadane_rpm;
    logic [RPM_W-1:0]  rpm;
    logic [TAKT_W-1:0] taktowanie_na_stopien;
    logic              sygnal_zmiany_rpm;
    logic              rozruch;
    logic              zajety;

    modport master (
        output start, zadane_rpm,
        input  rpm, taktowanie_na_stopien, sygnal_zmiany_rpm, rozruch, zajety
    );

    modport slave (
        input  start, zadane_rpm,
        output rpm, taktowanie_na_stopien, sygnal_zmiany_rpm, rozruch, zajety
    );

endinterface

// File: rtl/sekwencer_obrotow_dzielnik.sv
// 16-cycle restoring divider: DZIELNA / dzielnik_i, saturated to TAKT_MAX, 0 for divisor 0.
module dzielnik_taktowania
    import sekwencer_pkg::*;
#(
    parameter logic [DZIELNA_W-1:0] DZIELNA = 16'd480
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [RPM_W-1:0]  dzielnik_i,
    output logic              gotowy_o,
    output logic              zajety_o,
    output logic [TAKT_W-1:0] wynik_o
);

    logic                 zajety_q;
    logic [3:0]           krok_q;
    logic [RPM_W-1:0]     reszta_q;
    logic [RPM_W-1:0]     dzielnik_q;
    logic [DZIELNA_W-1:0] iloraz_q;

    logic [RPM_W:0]       czesc;
    logic [RPM_W-1:0]     roznica;
    logic                 miesci;
    logic [RPM_W-1:0]     reszta_nast;
    logic [DZIELNA_W-1:0] iloraz_nast;

    always_comb begin
        czesc       = {reszta_q, iloraz_q[DZIELNA_W-1]};
        miesci      = (czesc >= {1'b0, dzielnik_q});
        roznica     = RPM_W'(czesc - {1'b0, dzielnik_q});
        reszta_nast = miesci ? roznica : czesc[RPM_W-1:0];
        iloraz_nast = {iloraz_q[DZIELNA_W-2:0], miesci};
    end

    // The last step's quotient is presented combinationally so the caller can register it on gotowy_o.
    always_comb begin
        gotowy_o = zajety_q && (krok_q == 4'd15);
        if (dzielnik_q == '0)
            wynik_o = '0;
        else if (iloraz_nast[DZIELNA_W-1:TAKT_W] != '0)
            wynik_o = TAKT_W'(TAKT_MAX);
        else
            wynik_o = iloraz_nast[TAKT_W-1:0];
    end

    assign zajety_o = zajety_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zajety_q   <= 1'b0;
            krok_q     <= '0;
            reszta_q   <= '0;
            dzielnik_q <= '0;
            iloraz_q   <= '0;
        end else if (start_i) begin
            zajety_q   <= 1'b1;
            krok_q     <= '0;
            reszta_q   <= '0;
            dzielnik_q <= dzielnik_i;
            iloraz_q   <= DZIELNA;
        end else if (zajety_q) begin
            reszta_q <= reszta_nast;
            iloraz_q <= iloraz_nast;
            krok_q   <= krok_q + 4'd1;
            if (krok_q == 4'd15)
                zajety_q <= 1'b0;
        end
    end

endmodule

// File: rtl/sekwencer_obrotow.sv
// Speed ramp sequencer feeding the LED driver; SEKWENCER_SKOK_ROZRUCHU_EN makes the first step min(8, target).
//   state     | meaning
//   STOP      | motor stopped, rpm = 0
//   RAMPA     | stepping rpm by 1 toward the target
//   PRACA     | holding rpm at the target
//   HAMOWANIE | stepping rpm down to 0
module sekwencer_obrotow
    import sekwencer_pkg::*;
#(
    parameter int                   KROK_TAKTY       = 1000,
    parameter logic [DZIELNA_W-1:0] STALA_TAKTOWANIA = 16'd480
) (
    input  logic                clk,
    input  logic                rst_n,
    sekwencer_obrotow_if.slave  bus
);

    localparam int TIMER_W = $clog2(KROK_TAKTY + 1);

    stan_t              stan_q, stan_d;
    logic [TIMER_W-1:0] timer_q;
    logic [RPM_W-1:0]   rpm_q;
    logic [RPM_W-1:0]   nowe_q, nowe_d;
    logic [RPM_W-1:0]   cel_q, cel_d;
    logic [TAKT_W-1:0]  takt_q;
    logic               strobe_q;
    logic               rozruch_q;

    logic               decyzja;
    logic               jedzie;
    logic               gotowy;
    logic               zajety;
    logic [TAKT_W-1:0]  wynik;

    dzielnik_taktowania #(.DZIELNA(STALA_TAKTOWANIA)) u_dzielnik (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (decyzja),
        .dzielnik_i (nowe_d),
        .gotowy_o   (gotowy),
        .zajety_o   (zajety),
        .wynik_o    (wynik)
    );

    // State only moves on the strobe or while the divider is idle, so inputs act at the next decision.
    always_comb begin
        stan_d  = stan_q;
        nowe_d  = nowe_q;
        cel_d   = cel_q;
        decyzja = 1'b0;
        jedzie  = bus.start && (bus.zadane_rpm != '0);
        if (gotowy) begin
            if (nowe_q == '0)
                stan_d = STOP;
            else if ((stan_q == RAMPA) && (nowe_q == cel_q))
                stan_d = PRACA;
        end else if (!zajety) begin
            unique case (stan_q)
                STOP: begin
                    if (jedzie) begin
                        decyzja = 1'b1;
                        cel_d   = bus.zadane_rpm;
                        stan_d  = RAMPA;
`ifdef SEKWENCER_SKOK_ROZRUCHU_EN
                        nowe_d  = (bus.zadane_rpm < RPM_W'(SKOK_ROZRUCHU)) ?
                                  bus.zadane_rpm : RPM_W'(SKOK_ROZRUCHU);
`else
                        nowe_d  = RPM_W'(1);
`endif
                    end
                end
                RAMPA: begin
                    if (!jedzie)
                        stan_d = HAMOWANIE;
                    else if (bus.zadane_rpm == rpm_q)
                        stan_d = PRACA;
                    else if (timer_q == '0) begin
                        decyzja = 1'b1;
                        nowe_d  = krok_ku(rpm_q, bus.zadane_rpm);
                        cel_d   = bus.zadane_rpm;
                    end
                end
                PRACA: begin
                    if (!jedzie)
                        stan_d = HAMOWANIE;
                    else if (bus.zadane_rpm != rpm_q)
                        stan_d = RAMPA;
                end
                HAMOWANIE: begin
                    if (jedzie)
                        stan_d = RAMPA;
                    else if (timer_q == '0) begin
                        decyzja = 1'b1;
                        nowe_d  = rpm_q - RPM_W'(1);
                        cel_d   = '0;
                    end
                end
                default: stan_d = STOP;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stan_q    <= STOP;
            timer_q   <= '0;
            rpm_q     <= '0;
            nowe_q    <= '0;
            cel_q     <= '0;
            takt_q    <= '0;
            strobe_q  <= 1'b0;
            rozruch_q <= 1'b0;
        end else begin
            stan_q   <= stan_d;
            nowe_q   <= nowe_d;
            cel_q    <= cel_d;
            strobe_q <= gotowy;
            if (gotowy) begin
                rpm_q     <= nowe_q;
                takt_q    <= wynik;
                rozruch_q <= (nowe_q != '0);
                timer_q   <= TIMER_W'(KROK_TAKTY);
            end else if (timer_q != '0) begin
                timer_q <= timer_q - TIMER_W'(1);
            end
        end
    end

    assign bus.rpm                   = rpm_q;
    assign bus.taktowanie_na_stopien = takt_q;
    assign bus.sygnal_zmiany_rpm     = strobe_q;
    assign bus.rozruch               = rozruch_q;
    assign bus.zajety                = zajety;

endmodule

// File: tb/tb_sekwencer_obrotow.sv
// Scoreboard bench for sekwencer_obrotow: expected strobes come from a step-list model of the ramp rules.
module tb_sekwencer_obrotow;
    import sekwencer_pkg::*;

    localparam int KROK_A = 4;
    localparam int K_A    = 480;
    localparam int KROK_B = 3;
    localparam int K_B    = 1000;

    typedef struct {
        int rpm;
        int takt;
        int rozruch;
    } oczek_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    oczek_t exp_q[$];
    int     t_strobe[$];
    int     plan[$];
    int     n_chk = 0;
    int     n_err = 0;
    int     model_rpm = 0;

    sekwencer_obrotow_if bus_a();
    sekwencer_obrotow_if bus_b();

    sekwencer_obrotow #(.KROK_TAKTY(KROK_A), .STALA_TAKTOWANIA(16'(K_A))) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    sekwencer_obrotow #(.KROK_TAKTY(KROK_B), .STALA_TAKTOWANIA(16'(K_B))) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int takt_ref(int k, int r);
        if (r == 0) return 0;
        return (k / r > TAKT_MAX) ? TAKT_MAX : k / r;
    endfunction

    // Sequence of rpm values the sequencer must present, one per strobe.
    function automatic void plan_steps(int cur, bit st, int tgt);
        int r;
        plan.delete();
        if (!st || tgt == 0) begin
            for (int i = cur - 1; i >= 0; i--) plan.push_back(i);
        end else begin
            r = cur;
            if (cur == 0) begin
`ifdef SEKWENCER_SKOK_ROZRUCHU_EN
                r = (tgt < SKOK_ROZRUCHU) ? tgt : SKOK_ROZRUCHU;
`else
                r = 1;
`endif
                plan.push_back(r);
            end
            while (r != tgt) begin
                r = (r < tgt) ? r + 1 : r - 1;
                plan.push_back(r);
            end
        end
    endfunction

    task automatic chk(string nm, int act, int req);
        n_chk++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic issue(bit st, int tgt);
        oczek_t e;
        plan_steps(model_rpm, st, tgt);
        foreach (plan[i]) begin
            e.rpm     = plan[i];
            e.takt    = takt_ref(K_A, plan[i]);
            e.rozruch = (plan[i] != 0) ? 1 : 0;
            exp_q.push_back(e);
        end
        if (plan.size() > 0) model_rpm = plan[plan.size() - 1];
        bus_a.start      = st;
        bus_a.zadane_rpm = 7'(tgt);
    endtask

    task automatic settle();
        int budget;
        budget = (exp_q.size() + 1) * (KROK_A + 17) + 40;
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_chk++;
            n_err++;
            $display("FAIL settle_timeout: pending=%0d required=0", exp_q.size());
            exp_q.delete();
        end
        repeat (60) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && bus_a.sygnal_zmiany_rpm) begin
            oczek_t e;
            t_strobe.push_back(cyc);
            n_chk++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL strobe_unexpected: rpm=%0d takt=%0d, required no strobe",
                         bus_a.rpm, bus_a.taktowanie_na_stopien);
            end else begin
                e = exp_q.pop_front();
                if (int'(bus_a.rpm) != e.rpm || int'(bus_a.taktowanie_na_stopien) != e.takt ||
                    int'(bus_a.rozruch) != e.rozruch) begin
                    n_err++;
                    $display("FAIL strobe_values: rpm=%0d takt=%0d rozruch=%0d required rpm=%0d takt=%0d rozruch=%0d",
                             bus_a.rpm, bus_a.taktowanie_na_stopien, bus_a.rozruch,
                             e.rpm, e.takt, e.rozruch);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int n;
        bit st;
        int tgt;
        bit seen;

        rst_n = 1'b0;
        bus_a.start = 1'b0; bus_a.zadane_rpm = '0;
        bus_b.start = 1'b0; bus_b.zadane_rpm = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rpm", int'(bus_a.rpm), 0);
        chk("reset_takt", int'(bus_a.taktowanie_na_stopien), 0);
        chk("reset_strobe", int'(bus_a.sygnal_zmiany_rpm), 0);
        chk("reset_rozruch", int'(bus_a.rozruch), 0);
        chk("reset_zajety", int'(bus_a.zajety), 0);
        rst_n = 1'b1;

        repeat (40) @(posedge clk);
        #1;
        chk("idle_no_strobe", t_strobe.size(), 0);
        chk("idle_rpm", int'(bus_a.rpm), 0);
        chk("idle_zajety", int'(bus_a.zajety), 0);

        // Async reset in the middle of the first division.
        bus_a.start = 1'b1; bus_a.zadane_rpm = 7'd5;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("div_busy_cycle10", int'(bus_a.zajety), 1);
        rst_n = 1'b0;
        #1;
        chk("midreset_zajety", int'(bus_a.zajety), 0);
        chk("midreset_rpm", int'(bus_a.rpm), 0);
        chk("midreset_rozruch", int'(bus_a.rozruch), 0);
        bus_a.start = 1'b0; bus_a.zadane_rpm = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("midreset_no_strobe", t_strobe.size(), 0);

        // Ramp 0 -> 5 with strobe timing.
        t_strobe.delete();
        c0 = cyc;
        issue(1'b1, 5);
        n = plan.size();
        settle();
        chk("ramp_strobe_count", t_strobe.size(), n);
        for (int i = 0; i < n && i < t_strobe.size(); i++)
            chk($sformatf("ramp_strobe_cycle%0d", i), t_strobe[i] - c0, 17 + i * (KROK_A + 17));
        chk("praca_rozruch", int'(bus_a.rozruch), 1);
        chk("praca_zajety", int'(bus_a.zajety), 0);

        issue(1'b1, 3);
        settle();
        chk("down_to3_rozruch", int'(bus_a.rozruch), 1);
        chk("down_to3_rpm", int'(bus_a.rpm), 3);
        issue(1'b1, 5);
        settle();
        issue(1'b0, 5);
        settle();
        chk("brake_rozruch", int'(bus_a.rozruch), 0);
        chk("brake_rpm", int'(bus_a.rpm), 0);
        chk("brake_takt", int'(bus_a.taktowanie_na_stopien), 0);

        for (int ep = 0; ep < 14; ep++) begin
            st  = ($urandom_range(0, 3) != 0);
            tgt = $urandom_range(0, 12);
            issue(st, tgt);
            settle();
            chk($sformatf("rand%0d_rpm", ep), int'(bus_a.rpm), model_rpm);
        end

        // Saturation with K=1000 on the second instance.
        plan_steps(0, 1'b1, 2);
        bus_b.start = 1'b1; bus_b.zadane_rpm = 7'd2;
        foreach (plan[i]) begin
            seen = 1'b0;
            for (int w = 0; w < 80 && !seen; w++) begin
                @(negedge clk);
                if (bus_b.sygnal_zmiany_rpm) seen = 1'b1;
            end
            chk($sformatf("sat_strobe%0d_seen", i), int'(seen), 1);
            chk($sformatf("sat_strobe%0d_rpm", i), int'(bus_b.rpm), plan[i]);
            chk($sformatf("sat_strobe%0d_takt", i), int'(bus_b.taktowanie_na_stopien),
                takt_ref(K_B, plan[i]));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/sekwencer_obrotow.md
# sekwencer_obrotow

Speed sequencer that drives the LED driver's speed inputs (`rpm`, `sygnal_zmiany_rpm`, `rozruch`, `taktowanie_na_stopien`) from a user target speed and a start switch. It ramps `rpm` one unit per step toward the target, or down to stop. For each new speed it computes clocks-per-degree with a sequential divider and presents the result with a one-cycle change strobe. It sits between the control inputs and `sterownik_Ledow`, whose ports it connects to one-to-one.

## Interface
- `KROK_TAKTY`, default 1000: idle clocks between consecutive ramp steps; must be ≥1.
- `STALA_TAKTOWANIA`, default 480: 16-bit constant K; `taktowanie_na_stopien` = K / rpm.
- `clk`  in  1: system clock. All logic is on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: level input. 1 = run the motor; 0 = brake to stop.
- `zadane_rpm`  in  7: target speed. It is sampled only at step decisions.
- `rpm`  out  7: current speed, to the LED driver.
- `taktowanie_na_stopien`  out  9: clocks per degree, to the LED driver.
- `sygnal_zmiany_rpm`  out  1: one-cycle strobe. `rpm` and `taktowanie_na_stopien` are valid and new in that cycle.
- `rozruch`  out  1: motor-enabled flag, to the LED driver.
- `zajety`  out  1: high while a step is being computed, i.e. the divider is busy.

## Operation
- Reset: `rpm`=0, `taktowanie_na_stopien`=0, `sygnal_zmiany_rpm`=0, `rozruch`=0, `zajety`=0, state STOP, timer=0.
- States:
  - STOP: the motor is stopped.
  - RAMPA: ramping toward the target.
  - PRACA: steady at the target.
  - HAMOWANIE: braking to 0.
- Step decision: computes `nowe_rpm`, launches the divider, and sets `zajety`. No new decision is made while `zajety`=1.
- STOP → RAMPA: when `start`=1 and `zadane_rpm`≠0. The decision is made immediately, with `nowe_rpm`=1.
- RAMPA: when the timer expires, `nowe_rpm` = rpm±1 toward `zadane_rpm`.
  - The strobe that brings rpm equal to the target moves the FSM to PRACA.
- PRACA: no steps occur.
  - `zadane_rpm`≠rpm → RAMPA. The first decision waits for the timer.
- `start`=0 or `zadane_rpm`=0 in RAMPA or PRACA → HAMOWANIE.
- HAMOWANIE: each timer expiry gives `nowe_rpm`=rpm−1.
  - The strobe that sets rpm=0 moves the FSM to STOP.
  - `start`=1 with `zadane_rpm`≠0 → RAMPA from the current rpm. A step already in the divider completes unchanged.
- Division: unsigned restoring division, 16-bit dividend K by 7-bit divisor.
  - The result saturates to 511.
  - Divisor 0 → quotient 0, with the same latency.
- `rozruch`:
  - Rises with the first strobe out of STOP.
  - Falls with the strobe that sets rpm=0.
- Changes to `start` or `zadane_rpm` during a division take effect at the next decision.

## Timing
- Decision at cycle T. `zajety`=1 in T+1..T+16. Outputs are registered and `sygnal_zmiany_rpm`=1 at T+17.
- The timer clears at the strobe. The next decision falls KROK_TAKTY cycles after the strobe.
  - Strobe-to-strobe spacing while ramping = KROK_TAKTY+17.
- Start from STOP: `start` sampled high at cycle 0 → first strobe at cycle 17.
- Async reset mid-division: all outputs clear immediately. No strobe is issued after release.
- All outputs are registered. No combinational path runs from inputs to outputs.

## Configuration
- `SEKWENCER_SKOK_ROZRUCHU_EN`: when defined, leaving STOP uses `nowe_rpm` = min(8, `zadane_rpm`) instead of 1. Ramping then continues ±1.
- When undefined, ramping always starts at 1.
- Braking behaviour is unaffected either way.

## Structure
- Package `sekwencer_pkg` holds:
  - `RPM_W`=7 and `TAKT_W`=9.
  - `TAKT_MAX`=511.
  - The state typedef `stan_t` {STOP, RAMPA, PRACA, HAMOWANIE}.
  - `SKOK_ROZRUCHU`=8.
- Sub-module `dzielnik_taktowania`: a 16-cycle sequential divider with a `start`/`gotowy` handshake and saturation.
- The top level holds the FSM, the step timer, and the output registers.

## Test plan
- Reset, then idle with `start`=0 → all outputs 0. No strobe ever occurs.
- KROK_TAKTY=4, K=480, `zadane_rpm`=5, `start`=1 at cycle 0:
  - Strobes at cycles 17, 38, 59, 80, 101.
  - rpm 1..5, taktowanie 480, 240, 160, 120, 96.
  - `rozruch`=1 from cycle 17. PRACA follows, with no further strobes.
- In PRACA at rpm 5, drop `start`:
  - rpm steps 4, 3, 2, 1, 0, with taktowanie 120, 160, 240, 480, 0.
  - `rozruch` falls with the last strobe. The FSM ends in STOP.
- In PRACA at rpm 5, set `zadane_rpm`=3 → exactly 2 strobes (rpm 4, 3). `rozruch` stays 1.
- K=1000 with rpm stepping to 1 → taktowanie saturates to 511. At rpm 2 → 500.
- Pulse `rst_n` low at cycle 10 of the first division → outputs 0 immediately. No strobe at cycle 17.
- With the macro defined and `zadane_rpm`=5, the first strobe gives rpm 5.
